// File: rtl/mem_port_arbiter.sv
// Steps the core through data access, instruction fetch and a clk_en pulse on one RAM port.
// Optional single-entry fetch buffer: define MEM_PORT_ARBITER_FETCH_BUF_EN.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 31
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  output logic                  o_core_clk_en,
  input  logic [ADDR_WIDTH:0]   i_fetch_addr,
  output logic [DATA_WIDTH:0]   o_fetch_data,
  input  logic                  i_read_req,
  input  logic [ADDR_WIDTH:0]   i_read_addr,
  output logic [DATA_WIDTH:0]   o_read_data,
  input  logic                  i_write_enable,
  input  logic [3:0]            i_byte_enable,
  input  logic [ADDR_WIDTH:0]   i_write_addr,
  input  logic [DATA_WIDTH:0]   i_write_data,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_be,
  output logic [ADDR_WIDTH:0]   o_mem_addr,
  output logic [DATA_WIDTH:0]   o_mem_wdata,
  input  logic [DATA_WIDTH:0]   i_mem_rdata,
  input  logic                  i_mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FETCH,
    STEP
  } state_t;

  state_t state;
  logic   skip_idle;
  logic   skip_data;

  assign o_core_clk_en = clk_en && (state == STEP);

`ifdef MEM_PORT_ARBITER_FETCH_BUF_EN
  logic [ADDR_WIDTH:0] tag;
  logic                tag_vld;
  logic                wr_kill;

  // A write landing on the buffered word must not be followed by a hit.
  assign wr_kill   = o_mem_we && (o_mem_addr == tag);
  assign skip_idle = tag_vld && (i_fetch_addr == tag);
  assign skip_data = tag_vld && !wr_kill && (i_fetch_addr == tag);

  always_ff @(posedge clk) begin
    if (rst) begin
      tag     <= '0;
      tag_vld <= 1'b0;
    end else begin
      if (state == DATA && i_mem_ready && wr_kill)
        tag_vld <= 1'b0;
      if (state == FETCH && i_mem_ready) begin
        tag     <= o_mem_addr;
        tag_vld <= 1'b1;
      end
    end
  end
`else
  assign skip_idle = 1'b0;
  assign skip_data = 1'b0;
`endif

  // The o_mem_* registers double as the latched data request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      o_mem_req    <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_be     <= 4'h0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_fetch_data <= '0;
      o_read_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clk_en) begin
            if (i_write_enable) begin
              o_mem_req   <= 1'b1;
              o_mem_we    <= 1'b1;
              o_mem_be    <= i_byte_enable;
              o_mem_addr  <= i_write_addr;
              o_mem_wdata <= i_write_data;
              state       <= DATA;
            end else if (i_read_req) begin
              o_mem_req  <= 1'b1;
              o_mem_we   <= 1'b0;
              o_mem_be   <= 4'hf;
              o_mem_addr <= i_read_addr;
              state      <= DATA;
            end else if (skip_idle) begin
              state <= STEP;
            end else begin
              o_mem_req  <= 1'b1;
              o_mem_we   <= 1'b0;
              o_mem_be   <= 4'hf;
              o_mem_addr <= i_fetch_addr;
              state      <= FETCH;
            end
          end
        end
        DATA: begin
          if (i_mem_ready) begin
            if (!o_mem_we)
              o_read_data <= i_mem_rdata;
            o_mem_we <= 1'b0;
            if (skip_data) begin
              o_mem_req <= 1'b0;
              o_mem_be  <= 4'h0;
              state     <= STEP;
            end else begin
              o_mem_req  <= 1'b1;
              o_mem_be   <= 4'hf;
              o_mem_addr <= i_fetch_addr;
              state      <= FETCH;
            end
          end
        end
        FETCH: begin
          if (i_mem_ready) begin
            o_fetch_data <= i_mem_rdata;
            o_mem_req    <= 1'b0;
            o_mem_be     <= 4'h0;
            state        <= STEP;
          end
        end
        STEP: begin
          if (clk_en)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected RAM transactions and step
// results are queued at stimulus time and checked as the DUT produces them.
module tb_mem_port_arbiter;

`ifdef MEM_PORT_ARBITER_FETCH_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        o_core_clk_en;
  logic [31:0] i_fetch_addr;
  logic [31:0] o_fetch_data;
  logic        i_read_req;
  logic [31:0] i_read_addr;
  logic [31:0] o_read_data;
  logic        i_write_enable;
  logic [3:0]  i_byte_enable;
  logic [31:0] i_write_addr;
  logic [31:0] i_write_data;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
  logic        i_mem_ready;

  mem_port_arbiter #(.ADDR_WIDTH(31), .DATA_WIDTH(31)) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .o_core_clk_en (o_core_clk_en),
    .i_fetch_addr  (i_fetch_addr),
    .o_fetch_data  (o_fetch_data),
    .i_read_req    (i_read_req),
    .i_read_addr   (i_read_addr),
    .o_read_data   (o_read_data),
    .i_write_enable(i_write_enable),
    .i_byte_enable (i_byte_enable),
    .i_write_addr  (i_write_addr),
    .i_write_data  (i_write_data),
    .o_mem_req     (o_mem_req),
    .o_mem_we      (o_mem_we),
    .o_mem_be      (o_mem_be),
    .o_mem_addr    (o_mem_addr),
    .o_mem_wdata   (o_mem_wdata),
    .i_mem_rdata   (i_mem_rdata),
    .i_mem_ready   (i_mem_ready)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [31:0] fetch;
    logic [31:0] read;
    int          lat;
  } step_t;

  txn_t  txn_q[$];
  step_t step_q[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] ram     [0:255];
  logic [31:0] exp_mem [0:255];
  logic [31:0] exp_fetch;
  logic [31:0] exp_read;
  logic [31:0] btag;
  logic        bvalid;
  int          wait_cfg;
  int          wcnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM environment with a configurable number of wait states per request
  assign i_mem_rdata = ram[o_mem_addr[7:0]];
  assign i_mem_ready = o_mem_req && (wcnt >= wait_cfg);

  always @(posedge clk) begin
    if (rst || !o_mem_req || i_mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (o_mem_req && i_mem_ready && o_mem_we)
      for (int b = 0; b < 4; b++)
        if (o_mem_be[b]) ram[o_mem_addr[7:0]][8*b +: 8] <= o_mem_wdata[8*b +: 8];
  end

  // Monitor: transaction completions, wait-state stability, step pulses
  int          cyc = 0;
  int          last_pulse = 0;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    txn_t  t;
    step_t s;
    cyc++;
    if (rst) begin
      last_pulse = cyc;
      prev_wait  = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("wait_req_hold", o_mem_req, 1'b1);
        chk("wait_addr_hold", o_mem_addr, prev_addr);
      end
      prev_wait = o_mem_req && !i_mem_ready;
      prev_addr = o_mem_addr;
      if (o_mem_req && i_mem_ready) begin
        if (txn_q.size() == 0) begin
          chk("txn_unexpected", o_mem_addr, 64'hffff_ffff_ffff_ffff);
        end else begin
          t = txn_q.pop_front();
          chk("txn_we", o_mem_we, t.we);
          chk("txn_be", o_mem_be, t.be);
          chk("txn_addr", o_mem_addr, t.addr);
          if (t.we) chk("txn_wdata", o_mem_wdata, t.wdata);
        end
      end
      if (o_core_clk_en) begin
        if (step_q.size() == 0) begin
          chk("pulse_unexpected", o_core_clk_en, 1'b0);
        end else begin
          s = step_q.pop_front();
          chk("txn_pending", txn_q.size(), 0);
          chk("fetch_data", o_fetch_data, s.fetch);
          chk("read_data", o_read_data, s.read);
          chk("step_cycles", cyc - last_pulse, s.lat);
        end
        last_pulse = cyc;
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1;
    txn_q.delete();
    step_q.delete();
    repeat (n) @(posedge clk);
    #1;
    chk("rst_core_clk_en", o_core_clk_en, 1'b0);
    chk("rst_mem_req", o_mem_req, 1'b0);
    chk("rst_mem_we", o_mem_we, 1'b0);
    chk("rst_mem_be", o_mem_be, 4'h0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_mem_wdata", o_mem_wdata, 32'h0);
    chk("rst_fetch_data", o_fetch_data, 32'h0);
    chk("rst_read_data", o_read_data, 32'h0);
    exp_fetch = '0;
    exp_read  = '0;
    bvalid    = 1'b0;
    btag      = '0;
    rst = 1'b0;
  endtask

  task automatic do_step(input logic we, input logic rd,
                         input logic [31:0] waddr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] raddr,
                         input logic [31:0] faddr, input int waits, input int gap);
    txn_t  t;
    step_t s;
    logic  hit;
    int    lat;
    i_write_enable = we;
    i_read_req     = rd;
    i_write_addr   = waddr;
    i_write_data   = wdata;
    i_byte_enable  = be;
    i_read_addr    = raddr;
    i_fetch_addr   = faddr;
    wait_cfg       = waits;
    lat = 2;
    if (we) begin
      t = '{we: 1'b1, be: be, addr: waddr, wdata: wdata};
      txn_q.push_back(t);
      for (int b = 0; b < 4; b++)
        if (be[b]) exp_mem[waddr[7:0]][8*b +: 8] = wdata[8*b +: 8];
      if (waddr == btag) bvalid = 1'b0;
      lat += 1 + waits;
    end else if (rd) begin
      t = '{we: 1'b0, be: 4'hf, addr: raddr, wdata: 32'h0};
      txn_q.push_back(t);
      exp_read = exp_mem[raddr[7:0]];
      lat += 1 + waits;
    end
    hit = BUF && bvalid && (faddr == btag);
    if (!hit) begin
      t = '{we: 1'b0, be: 4'hf, addr: faddr, wdata: 32'h0};
      txn_q.push_back(t);
      exp_fetch = exp_mem[faddr[7:0]];
      btag      = faddr;
      bvalid    = 1'b1;
      lat += 1 + waits;
    end
    if (gap > 0 && lat < gap + 2) lat = gap + 2;
    s = '{fetch: exp_fetch, read: exp_read, lat: lat};
    step_q.push_back(s);
    if (gap > 0) begin
      @(posedge clk);
      #1;
      clk_en = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
      clk_en = 1'b1;
    end
    for (int i = 0; i < 200; i++) begin
      if (step_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    if (step_q.size() != 0) begin
      chk("step_timeout", step_q.size(), 0);
      step_q.delete();
      txn_q.delete();
    end
  endtask

  initial begin
    rst            = 1'b1;
    clk_en         = 1'b1;
    i_fetch_addr   = '0;
    i_read_req     = 1'b0;
    i_read_addr    = '0;
    i_write_enable = 1'b0;
    i_byte_enable  = 4'h0;
    i_write_addr   = '0;
    i_write_data   = '0;
    wait_cfg       = 0;
    for (int i = 0; i < 256; i++) ram[i] = 32'h1357_0000 + 32'(i);
    ram[8'h10] = 32'h0050_0093;
    ram[8'h14] = 32'h0000_0013;
    ram[8'h18] = 32'h0010_0073;
    ram[8'h20] = 32'hDEAD_BEEF;
    ram[8'h08] = 32'h1122_3344;
    for (int i = 0; i < 256; i++) exp_mem[i] = ram[i];

    do_reset(3);

    // fetch-only steps
    for (int k = 0; k < 3; k++)
      do_step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h10, 0, 0);
    // read steps
    for (int k = 0; k < 2; k++)
      do_step(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h20, 32'h10, 0, 0);
    // write wins over a simultaneous read
    do_step(1'b1, 1'b1, 32'h08, 32'h0000_ABCD, 4'b0011, 32'h20, 32'h10, 0, 0);
    do_step(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h08, 32'h10, 0, 0);
    // wait states
    do_step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h14, 5, 0);
    do_step(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h20, 32'h14, 2, 0);
    // clk_en low while the step runs
    do_step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h18, 0, 4);
    do_step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h10, 0, 0);
    do_step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h10, 0, 0);
    // overwrite the buffered instruction word
    do_step(1'b1, 1'b0, 32'h10, 32'h00A0_0113, 4'hf, 32'h0, 32'h10, 0, 0);
    do_step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h10, 1, 0);

    // reset in the middle of a stalled data access
    i_read_req  = 1'b1;
    i_read_addr = 32'h20;
    wait_cfg    = 10;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_req", o_mem_req, 1'b1);
    do_reset(1);
    i_read_req = 1'b0;
    wait_cfg   = 0;
    do_step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h10, 0, 0);
    do_step(1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h08, 32'h10, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
